piso_tx: RTL and testbench

Parallel-in serial-out transmitter: accepts a `width`-bit word over a load/ready handshake, then shifts it out one bit per bit period with a frame strobe and a completion pulse. It sits on the output side of our parallel register datapath. It takes the word held in a parallel holding register and serialises it for a single-wire link; the serial-to-parallel receiver is the matching block at the far end.

---
 rtl/piso_tx.sv | 127 ++++++++++++
 tb/tb_piso_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts a width-bit word over a load/ready handshake and shifts it out one
// bit per DIV clock cycles. frame_o marks the driven bits and done_o pulses
// once in the first idle cycle after the last bit period.
//
// Handshake: a word is taken on a rising edge where load=1 and ready_o=1.
// While a frame is in flight ready_o=0 and load/data_i are ignored (no
// queuing). ready_o returns high in the done_o cycle, so a load held there
// starts the next frame immediately.
module piso_tx #(
  parameter int width     = 16,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [width-1:0] data_i,
  output logic             ready_o,
  output logic             sdata_o,
  output logic             frame_o,
  output logic             done_o,
  output logic             dbg_state_o
);

  localparam int BW = $clog2(width);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             sdata_q, sdata_d;
  logic             frame_q, frame_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Next-state logic. The shift register always holds the bits not yet
  // driven, aligned so the next one to send sits at the transmit end.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sdata_d   = sdata_q;
    frame_d   = frame_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = SHIFT;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = DIV_LAST;
          frame_d   = 1'b1;
          ready_d   = 1'b0;
          if (MSB_FIRST) begin
            sdata_d = data_i[width-1];
            shreg_d = {data_i[width-2:0], 1'b0};
          end else begin
            sdata_d = data_i[0];
            shreg_d = {1'b0, data_i[width-1:1]};
          end
        end
      end
      SHIFT: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - 1'b1;
        end else if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          div_cnt_d = DIV_LAST;
          if (MSB_FIRST) begin
            sdata_d = shreg_q[width-1];
            shreg_d = {shreg_q[width-2:0], 1'b0};
          end else begin
            sdata_d = shreg_q[0];
            shreg_d = {1'b0, shreg_q[width-1:1]};
          end
        end else begin
          state_d = IDLE;
          frame_d = 1'b0;
          sdata_d = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides everything, including load.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sdata_q   <= 1'b0;
      frame_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdata_q   <= sdata_d;
      frame_q   <= frame_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign ready_o     = ready_q;
  assign sdata_o     = sdata_q;
  assign frame_o     = frame_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: two instances (16-bit MSB-first DIV=1, and 8-bit
// LSB-first DIV=3). A reference model turns each accepted word into the list
// of per-cycle outputs it should produce; a monitor pops one entry per cycle.
module tb_piso_tx;

  localparam int W_A = 16;
  localparam int DIV_A = 1;
  localparam int W_B = 8;
  localparam int DIV_B = 3;

  // Expected entry layout: {ready, frame, sdata, done}
  localparam logic [3:0] IDLE_E = 4'b1000;
  localparam logic [3:0] DONE_E = 4'b1001;

  logic           clk;
  logic           clr_n;
  logic           load_a, load_b;
  logic [W_A-1:0] data_a;
  logic [W_B-1:0] data_b;
  logic           ready_a, sdata_a, frame_a, done_a, dbg_a;
  logic           ready_b, sdata_b, frame_b, done_b, dbg_b;

  logic [3:0] exp_qa[$];
  logic [3:0] exp_qb[$];
  logic       mon_en;
  int         vectors;
  int         miscompares;

  piso_tx #(.width(W_A), .DIV(DIV_A), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .clr_n(clr_n), .load(load_a), .data_i(data_a),
    .ready_o(ready_a), .sdata_o(sdata_a), .frame_o(frame_a),
    .done_o(done_a), .dbg_state_o(dbg_a)
  );

  piso_tx #(.width(W_B), .DIV(DIV_B), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .clr_n(clr_n), .load(load_b), .data_i(data_b),
    .ready_o(ready_b), .sdata_o(sdata_b), .frame_o(frame_b),
    .done_o(done_b), .dbg_state_o(dbg_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a word is accepted when load is high and nothing is
  // left to transmit (block idle or in its done cycle). Each bit occupies
  // DIV cycles in transmit order, followed by one done cycle.
  initial begin
    mon_en = 1'b0;
    forever begin
      @(posedge clk);
      if (!clr_n) begin
        exp_qa.delete();
        exp_qb.delete();
        mon_en = 1'b1;
      end else begin
        if (load_a && exp_qa.size() == 0) begin
          for (int k = 0; k < W_A; k++)
            for (int r = 0; r < DIV_A; r++)
              exp_qa.push_back({1'b0, 1'b1, data_a[W_A-1-k], 1'b0});
          exp_qa.push_back(DONE_E);
        end
        if (load_b && exp_qb.size() == 0) begin
          for (int k = 0; k < W_B; k++)
            for (int r = 0; r < DIV_B; r++)
              exp_qb.push_back({1'b0, 1'b1, data_b[k], 1'b0});
          exp_qb.push_back(DONE_E);
        end
      end
    end
  end

  // Monitor: one comparison per cycle per instance, state included
  // (SHIFT exactly when a frame is on the wire).
  initial begin
    logic [3:0] ea, eb;
    logic [4:0] act, expv;
    vectors = 0;
    miscompares = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ea = IDLE_E;
        eb = IDLE_E;
        if (exp_qa.size() > 0) ea = exp_qa.pop_front();
        if (exp_qb.size() > 0) eb = exp_qb.pop_front();
        act  = {dbg_a, ready_a, frame_a, sdata_a, done_a};
        expv = {ea[2], ea};
        vectors++;
        if (act !== expv) begin
          miscompares++;
          $display("FAIL dut_a t=%0t {state,ready,frame,sdata,done} got %b want %b", $time, act, expv);
        end
        act  = {dbg_b, ready_b, frame_b, sdata_b, done_b};
        expv = {eb[2], eb};
        vectors++;
        if (act !== expv) begin
          miscompares++;
          $display("FAIL dut_b t=%0t {state,ready,frame,sdata,done} got %b want %b", $time, act, expv);
        end
      end
    end
  end

  // Driver tasks
  task automatic pulse_a(input logic [W_A-1:0] d, input int hold);
    @(negedge clk);
    load_a = 1'b1;
    data_a = d;
    repeat (hold) @(negedge clk);
    load_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [W_B-1:0] d, input int hold);
    @(negedge clk);
    load_b = 1'b1;
    data_b = d;
    repeat (hold) @(negedge clk);
    load_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int budget;
    clr_n  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    idle(2);

    // Reference words on both instances
    pulse_a(16'hA5C3, 1);
    pulse_b(8'h81, 1);
    idle(30);

    // Busy rejection: second load lands around bit 4 of the frame
    pulse_a(16'hA5C3, 1);
    idle(3);
    pulse_a(16'hFFFF, 1);
    idle(20);

    // Back-to-back with load held high
    @(negedge clk);
    load_a = 1'b1;
    data_a = 16'h0001;
    @(negedge clk);
    data_a = 16'h8000;
    repeat (17) @(negedge clk);
    load_a = 1'b0;
    idle(20);

    // Reset mid-frame (around bit 5), then a fresh word
    pulse_a(16'h1234, 1);
    pulse_b(8'h5A, 1);
    idle(4);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    pulse_a(16'h00FF, 1);
    pulse_b(8'h0F, 1);
    idle(30);

    // Reset and load on the same edge
    @(negedge clk);
    clr_n  = 1'b0;
    load_a = 1'b1;
    load_b = 1'b1;
    data_a = 16'hBEEF;
    data_b = 8'hC3;
    @(negedge clk);
    clr_n  = 1'b1;
    load_a = 1'b0;
    load_b = 1'b0;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
      end
      @(negedge clk);
      load_a = $urandom_range(0, 1) == 1;
      load_b = $urandom_range(0, 1) == 1;
      data_a = W_A'($urandom);
      data_b = W_B'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        data_a = W_A'($urandom);
        data_b = W_B'($urandom);
      end
      repeat ($urandom_range(1, 10)) @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
    end

    // Drain with a bounded wait
    budget = 2000;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending a=%0d b=%0d required 0", exp_qa.size(), exp_qb.size());
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
